// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: FSM encoding,
// PC increment and the canonical no-op instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } fetch_state_t;

  localparam int PC_STEP = 4;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding {pc, instruction} entries for the fetch stage.
// The read pointer head is presented combinationally on dout; flush empties
// the buffer in one edge and takes priority over push and pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  // Qualify requests so the buffer can never underflow or overflow on its own.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (pop && (count_r != (AW+1)'(0))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (push && ((count_r != FULL_C) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; flush resets the ring to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observable while counted as valid.
  always_ff @(posedge clk) begin
    if (push_s && !flush) mem_r[wr_ptr_r] <= din;
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: walks sequential PCs, issues one outstanding request at a time
// to a variable-latency instruction memory, queues returned words with their
// PCs and hands them to the core over valid/ready. Branch redirects flush the
// queue; a request already in flight is completed and its data dropped.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
`ifdef FETCH_PERF_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       discard_count,
`endif
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int                CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_t        state_r;
  fetch_state_t        state_s;
  logic [ADDR_W-1:0]   fetch_pc_r;
  logic [ADDR_W-1:0]   hold_addr_r;
  logic [CW-1:0]       count_s;
  logic [CW-1:0]       count_after_s;
  logic [ADDR_W+31:0]  head_s;
  logic                push_s;
  logic                pop_s;
  logic                valid_s;

  assign valid_s       = (count_s != CW'(0));
  assign pop_s         = valid_s && instr_ready && !redirect;
  assign push_s        = (state_r == S_REQ) && mem_ack && !redirect;
  assign count_after_s = count_s + CW'(push_s) - CW'(pop_s);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + 32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect),
    .din   ({fetch_pc_r, mem_rdata}),
    .dout  (head_s),
    .count (count_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic: only start a request when a FIFO slot is guaranteed.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (redirect)               state_s = S_IDLE;
        else if (count_s < DEPTH_C) state_s = S_REQ;
        else                        state_s = S_IDLE;
      end
      S_REQ: begin
        if (mem_ack) begin
          if (redirect)                     state_s = S_IDLE;
          else if (count_after_s < DEPTH_C) state_s = S_REQ;
          else                              state_s = S_IDLE;
        end else if (redirect) begin
          state_s = S_DISCARD;
        end else begin
          state_s = S_REQ;
        end
      end
      S_DISCARD: begin
        if (mem_ack) state_s = S_IDLE;
        else         state_s = S_DISCARD;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Fetch PC: redirect target (word aligned) wins, else advance on accepted data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          fetch_pc_r <= RESET_PC;
    else if (redirect) fetch_pc_r <= redirect_pc & ALIGN_MASK;
    else if (push_s)   fetch_pc_r <= fetch_pc_r + ADDR_W'(PC_STEP);
  end

  // Capture the in-flight address so it stays on the bus while being discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_addr_r <= RESET_PC;
    else if ((state_r == S_REQ) && redirect && !mem_ack) hold_addr_r <= fetch_pc_r;
  end

  assign mem_req     = (state_r == S_REQ) || (state_r == S_DISCARD);
  assign mem_addr    = (state_r == S_DISCARD) ? hold_addr_r : fetch_pc_r;
  assign instr_valid = valid_s;
  assign instr       = valid_s ? head_s[31:0] : 32'h0;
  assign instr_pc    = valid_s ? head_s[ADDR_W+31:32] : '0;

`ifdef FETCH_PERF_EN
  logic drop_s;
  assign drop_s = mem_ack && (((state_r == S_REQ) && redirect) || (state_r == S_DISCARD));

  // Saturating count of cycles where the core waits on an empty buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cycles <= 32'h0;
    else if (instr_ready && !valid_s && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'h1;
  end

  // Saturating count of memory responses thrown away due to a redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) discard_count <= 32'h0;
    else if (drop_s && (discard_count != 32'hFFFF_FFFF))
      discard_count <= discard_count + 32'h1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Randomised and directed bench for instr_fetch_buffer against a queue-based
// model of the fetch behaviour. Build with FETCH_PERF_EN to cover counters.
module tb_instr_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  typedef logic [ADDR_W+31:0] entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]       stall_cycles;
  logic [31:0]       discard_count;
`endif

  instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr),
`ifdef FETCH_PERF_EN
    .stall_cycles(stall_cycles), .discard_count(discard_count),
`endif
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of delivered entries plus the outstanding request.
  entry_t      q[$];
  logic        m_busy, m_disc;
  logic [63:0] m_pc, m_addr;
  logic [31:0] m_stall, m_dcnt;
  int          wcnt, lat, lat_lo, lat_hi;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string tag);
    n_checks++;
    n_errors++;
    $display("FAIL %s: cycle bound expired at %0t", tag, $time);
  endtask

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ INSTR_NOP;
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0; m_disc = 1'b0;
    m_pc = 64'h0; m_addr = 64'h0;
    m_stall = 32'h0; m_dcnt = 32'h0;
    wcnt = 0;
    lat = lat_lo;
  endtask

  task automatic compare_outputs();
    check("mem_req", {63'h0, mem_req}, {63'h0, m_busy});
    check("mem_addr", mem_addr, m_busy ? m_addr : m_pc);
    check("instr_valid", {63'h0, instr_valid}, {63'h0, (q.size() != 0)});
    check("instr", {32'h0, instr}, (q.size() != 0) ? {32'h0, q[0][31:0]} : 64'h0);
    check("instr_pc", instr_pc, (q.size() != 0) ? q[0][95:32] : 64'h0);
`ifdef FETCH_PERF_EN
    check("stall_cycles", {32'h0, stall_cycles}, {32'h0, m_stall});
    check("discard_count", {32'h0, discard_count}, {32'h0, m_dcnt});
`endif
  endtask

  // One clock: check current outputs, drive inputs, advance the model.
  task automatic cycle(input logic rdy, input logic redir, input logic [63:0] rpc);
    logic        ack, ack_eff, busy0;
    logic [31:0] data;
    int          sz0;
    compare_outputs();
    ack  = m_busy && (wcnt >= lat);
    data = ack ? word_at(m_addr) : $urandom();
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    mem_ack     = ack | (!m_busy && ($urandom_range(0, 3) == 0));
    mem_rdata   = data;

    sz0     = q.size();
    ack_eff = m_busy && ack;
    busy0   = m_busy;
    if (rdy && sz0 == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (ack_eff && (redir || m_disc) && m_dcnt != 32'hFFFF_FFFF) m_dcnt++;
    if (redir) begin
      q.delete();
      m_pc = rpc & ~64'd3;
      if (m_busy && !ack_eff) m_disc = 1'b1;
      else begin m_busy = 1'b0; m_disc = 1'b0; end
    end else begin
      if (rdy && sz0 > 0) void'(q.pop_front());
      if (ack_eff) begin
        if (m_disc) begin
          m_busy = 1'b0; m_disc = 1'b0;
        end else begin
          q.push_back({m_addr, data});
          m_pc = m_pc + 64'd4;
          if (q.size() < DEPTH) m_addr = m_pc;
          else m_busy = 1'b0;
        end
      end else if (!m_busy && sz0 < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_pc;
      end
    end
    if (!busy0 || ack_eff) begin
      wcnt = 0;
      lat  = $urandom_range(lat_lo, lat_hi);
    end else begin
      wcnt++;
    end
    @(negedge clk);
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_lo = lo; lat_hi = hi;
    if (wcnt == 0) lat = $urandom_range(lo, hi);
  endtask

  initial begin
    logic        found;
`ifdef FETCH_PERF_EN
    logic [31:0] s0, d0;
`endif
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 64'h0; instr_ready = 1'b0;
    lat_lo = 0; lat_hi = 0;
    model_reset();
    @(negedge clk);
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait memory, always-ready core: one fetch per cycle.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 64'h0);

    // Core stalls: buffer fills to DEPTH, then drains and resumes.
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 64'h0);

    // 3-cycle memory; redirect one cycle after the request to 0x8.
    set_lat(3, 3);
    cycle(1'b1, 1'b1, 64'h0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_busy && !m_disc && m_addr == 64'h8 && wcnt == 1) found = 1'b1;
      else cycle(1'b1, 1'b0, 64'h0);
    end
    if (!found) bound_expired("wait_req_0x8");
`ifdef FETCH_PERF_EN
    d0 = discard_count;
`endif
    cycle(1'b1, 1'b1, 64'h200);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 64'h0);
`ifdef FETCH_PERF_EN
    check("discard_delta", {32'h0, discard_count - d0}, 64'd1);
`endif

    // Five ready cycles against an empty, slow-refilling buffer.
    set_lat(8, 8);
    cycle(1'b0, 1'b1, 64'h400);
`ifdef FETCH_PERF_EN
    s0 = stall_cycles;
`endif
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 64'h0);
`ifdef FETCH_PERF_EN
    check("stall_delta", {32'h0, stall_cycles - s0}, 64'd5);
`endif
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 64'h0);

    // Redirect to an unaligned target with a same-cycle pop and 3 entries held.
    set_lat(0, 0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (q.size() == 3) found = 1'b1;
      else cycle(1'b0, 1'b0, 64'h0);
    end
    if (!found) bound_expired("wait_three_entries");
    cycle(1'b1, 1'b1, 64'h103);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 64'h0);

    // PC wrap-around at the top of the address space.
    cycle(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 64'h0);

    // Random traffic: variable latency, ready and redirects.
    set_lat(0, 3);
    for (int i = 0; i < 1500; i++) begin
      logic        rd;
      logic [63:0] tgt;
      rd  = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                        : {32'($urandom), 32'($urandom)};
      cycle(1'($urandom_range(0, 2) != 0), rd, tgt);
    end

    // Reset in the middle of a slow transaction aborts immediately.
    set_lat(5, 5);
    cycle(1'b1, 1'b1, 64'h800);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 64'h0);
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;
    set_lat(0, 0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
